// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter and sequencer in front of a shared,
// externally instantiated registered adder. It accepts one operand pair at a
// time, waits out the adder latency, then returns the sum to the winner,
// tagged with the winner's index.
module adder_arbiter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_sum,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    input  logic                  rsp_ready,
    output logic                  busy
);

    // Latency counter must be able to hold ADD_LAT itself.
    localparam int unsigned CW = $clog2(ADD_LAT + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(ADD_LAT);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_EXT = (IDW + 1)'(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] winner;
    logic [IDW:0]   cand;
    logic [CW-1:0]  cnt;
    logic           found;
    logic           accept;
    logic           rsp_hs;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    // The candidate index is one bit wider so rr_ptr+k can exceed NREQ-1
    // before being folded back, which keeps non-power-of-two NREQ correct.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (cand >= NREQ_EXT) begin
                cand = cand - NREQ_EXT;
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
        accept = found && (state == ST_IDLE);
        rsp_hs = rsp_valid && rsp_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; grant is held off while reset is asserted
    // so requesters never see a grant that cannot be committed.
    always_comb begin
        req_ready = '0;
        busy      = (state != ST_IDLE);
        if (rst_n && accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Operand registers feeding the adder; held until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a <= '0;
            add_b <= '0;
        end else if (accept) begin
            add_a <= req_a[winner*WIDTH +: WIDTH];
            add_b <= req_b[winner*WIDTH +: WIDTH];
        end
    end

    // Winner index, remembered for tagging the response and advancing rr_ptr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id <= '0;
        end else if (accept) begin
            grant_id <= winner;
        end
    end

    // Latency counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if (state == ST_WAIT && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Response registers: capture the adder output once the latency has
    // elapsed, hold it under backpressure, and clear valid on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
        end else if (state == ST_WAIT && cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= add_sum;
            rsp_id    <= grant_id;
        end else if (state == ST_RESP && rsp_hs) begin
            rsp_valid <= 1'b0;
        end
    end

    // Round-robin pointer: moves past the served requester on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == ST_RESP && rsp_hs) begin
            rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter with a one-stage registered adder.
module tb_adder_arbiter;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned ADD_LAT = 1;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [3:0]  add_sum;
    logic        rsp_valid;
    logic [3:0]  rsp_sum;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic        busy;

    int passed;
    int total;

    adder_arbiter #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .IDW     (IDW),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // External registered adder, latency 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) add_sum <= '0;
        else        add_sum <= add_a + add_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
    endtask

    // Advance until rsp_valid is seen (bounded); lat = cycles waited, -1 on timeout.
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    // Issue a lone request, collect grant vector, response and latency;
    // finishes with the handshake edge (rsp_ready assumed high).
    task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] grant, output logic [3:0] sum,
                          output logic [1:0] rid, output int lat);
        set_ops(id, a, b);
        req_valid = 4'b0001 << id;
        #1;
        grant = req_ready;
        tick();
        req_valid = '0;
        wait_rsp(lat);
        sum = rsp_sum;
        rid = rsp_id;
        if (lat > 0) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        req_a = 16'h1234;
        req_b = 16'h5678;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (req_ready !== 4'h0) $display("FAIL reset_req_ready: got %h expected 0", req_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passed++;
        total++; if (rsp_sum !== 4'h0) $display("FAIL reset_rsp_sum: got %h expected 0", rsp_sum); else passed++;
        total++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); else passed++;
        total++; if (add_a !== 4'h0 || add_b !== 4'h0) $display("FAIL reset_add_ops: got a=%h b=%h expected 0 0", add_a, add_b); else passed++;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_ops(1, 4'h3, 4'h5);
        req_valid = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) $display("FAIL single_grant: got %b expected 0010", req_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single_busy_idle: got %b expected 0", busy); else passed++;
        tick();
        req_valid = '0;
        total++; if (req_ready !== 4'b0000) $display("FAIL single_grant_pulse: got %b expected 0000", req_ready); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL single_busy_wait: got %b expected 1", busy); else passed++;
        total++; if (add_a !== 4'h3 || add_b !== 4'h5) $display("FAIL single_add_ops: got a=%h b=%h expected 3 5", add_a, add_b); else passed++;
        tick();
        total++; if (rsp_valid !== 1'b0) $display("FAIL single_rsp_early: got %b expected 0", rsp_valid); else passed++;
        tick();
        total++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); else passed++;
        total++; if (rsp_sum !== 4'h8) $display("FAIL single_rsp_sum: got %h expected 8", rsp_sum); else passed++;
        total++; if (rsp_id !== 2'd1) $display("FAIL single_rsp_id: got %0d expected 1", rsp_id); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL single_busy_resp: got %b expected 1", busy); else passed++;
        tick();
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_after_hs: got valid=%b busy=%b expected 0 0", rsp_valid, busy); else passed++;
    endtask

    task automatic test_wrap();
        logic [3:0] grant;
        logic [3:0] sum;
        logic [1:0] rid;
        int lat;
        run_op(0, 4'hF, 4'h1, grant, sum, rid, lat);
        total++; if (grant !== 4'b0001) $display("FAIL wrap0_grant: got %b expected 0001", grant); else passed++;
        total++; if (sum !== 4'h0 || rid !== 2'd0) $display("FAIL wrap0_rsp: got sum=%h id=%0d expected 0 0", sum, rid); else passed++;
        total++; if (lat !== 2) $display("FAIL wrap0_latency: got %0d expected 2", lat); else passed++;
        run_op(3, 4'hA, 4'h9, grant, sum, rid, lat);
        total++; if (grant !== 4'b1000) $display("FAIL wrap1_grant: got %b expected 1000", grant); else passed++;
        total++; if (sum !== 4'h3 || rid !== 2'd3) $display("FAIL wrap1_rsp: got sum=%h id=%0d expected 3 3", sum, rid); else passed++;
    endtask

    task automatic test_fairness();
        logic [1:0] order [5];
        logic [3:0] sums  [4];
        logic [3:0] exp_grant;
        int lat;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        sums  = '{4'h3, 4'hF, 4'h1, 4'h2};
        set_ops(0, 4'h1, 4'h2);
        set_ops(1, 4'h7, 4'h8);
        set_ops(2, 4'hC, 4'h5);
        set_ops(3, 4'h9, 4'h9);
        req_valid = 4'hF;
        #1;
        for (int n = 0; n < 5; n++) begin
            exp_grant = 4'b0001 << order[n];
            total++; if (req_ready !== exp_grant) $display("FAIL fair_grant_%0d: got %b expected %b", n, req_ready, exp_grant); else passed++;
            tick();
            wait_rsp(lat);
            total++; if (lat !== 2) $display("FAIL fair_latency_%0d: got %0d expected 2", n, lat); else passed++;
            total++; if (rsp_id !== order[n] || rsp_sum !== sums[order[n]])
                $display("FAIL fair_rsp_%0d: got id=%0d sum=%h expected id=%0d sum=%h", n, rsp_id, rsp_sum, order[n], sums[order[n]]);
            else passed++;
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_pointer();
        logic [3:0] grant;
        logic [3:0] sum;
        logic [1:0] rid;
        int lat;
        run_op(2, 4'h4, 4'h4, grant, sum, rid, lat);
        total++; if (grant !== 4'b0100 || sum !== 4'h8 || rid !== 2'd2)
            $display("FAIL ptr_first: got grant=%b sum=%h id=%0d expected 0100 8 2", grant, sum, rid);
        else passed++;
        set_ops(1, 4'h2, 4'h2);
        set_ops(3, 4'h6, 4'h1);
        req_valid = 4'b1010;
        #1;
        total++; if (req_ready !== 4'b1000) $display("FAIL ptr_grant3: got %b expected 1000", req_ready); else passed++;
        tick();
        wait_rsp(lat);
        total++; if (lat !== 2 || rsp_id !== 2'd3 || rsp_sum !== 4'h7)
            $display("FAIL ptr_rsp3: got lat=%0d id=%0d sum=%h expected 2 3 7", lat, rsp_id, rsp_sum);
        else passed++;
        tick();
        total++; if (req_ready !== 4'b0010) $display("FAIL ptr_grant1: got %b expected 0010", req_ready); else passed++;
        tick();
        req_valid = '0;
        wait_rsp(lat);
        total++; if (lat !== 2 || rsp_id !== 2'd1 || rsp_sum !== 4'h4)
            $display("FAIL ptr_rsp1: got lat=%0d id=%0d sum=%h expected 2 1 4", lat, rsp_id, rsp_sum);
        else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        rsp_ready = 1'b0;
        set_ops(2, 4'h6, 4'h7);
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = 4'hF;
        wait_rsp(lat);
        total++; if (lat !== 2) $display("FAIL bp_latency: got %0d expected 2", lat); else passed++;
        for (int k = 0; k < 5; k++) begin
            total++; if (rsp_valid !== 1'b1 || rsp_sum !== 4'hD || rsp_id !== 2'd2)
                $display("FAIL bp_hold_%0d: got valid=%b sum=%h id=%0d expected 1 d 2", k, rsp_valid, rsp_sum, rsp_id);
            else passed++;
            total++; if (req_ready !== 4'b0000) $display("FAIL bp_no_grant_%0d: got %b expected 0000", k, req_ready); else passed++;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_handshake: got valid=%b busy=%b expected 0 0", rsp_valid, busy); else passed++;
        total++; if (req_ready !== 4'b1000) $display("FAIL bp_next_grant: got %b expected 1000", req_ready); else passed++;
        req_valid = '0;
        #1;
        total++; if (req_ready !== 4'b0000) $display("FAIL bp_withdraw: got %b expected 0000", req_ready); else passed++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL bp_no_commit: got busy=%b expected 0", busy); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        int seen;
        set_ops(0, 4'h2, 4'h3);
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = '0;
        total++; if (busy !== 1'b1) $display("FAIL rst_accepted: got busy=%b expected 1", busy); else passed++;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'h0)
            $display("FAIL rst_async_ctrl: got busy=%b valid=%b ready=%b expected 0 0 0000", busy, rsp_valid, req_ready);
        else passed++;
        total++; if (add_a !== 4'h0 || add_b !== 4'h0 || rsp_sum !== 4'h0 || rsp_id !== 2'd0)
            $display("FAIL rst_async_data: got a=%h b=%h sum=%h id=%0d expected 0 0 0 0", add_a, add_b, rsp_sum, rsp_id);
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rsp_valid) seen++;
        end
        total++; if (seen !== 0) $display("FAIL rst_no_response: got %0d responses expected 0", seen); else passed++;
        set_ops(0, 4'h4, 4'h4);
        set_ops(3, 4'h1, 4'h1);
        req_valid = 4'b1001;
        #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL rst_ptr_cleared: got %b expected 0001", req_ready); else passed++;
        tick();
        req_valid = '0;
        wait_rsp(lat);
        total++; if (lat !== 2 || rsp_id !== 2'd0 || rsp_sum !== 4'h8)
            $display("FAIL rst_recover: got lat=%0d id=%0d sum=%h expected 2 0 8", lat, rsp_id, rsp_sum);
        else passed++;
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_pointer();
        test_backpressure();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one registered adder among NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the pair into the adder. It waits out the adder's fixed latency, then returns the captured sum to the winning requester, tagged with its index, over a valid/ready response channel. It sits between the requester blocks and the `adder` datapath, which it instantiates externally through its `add_*` ports.

## Interface
- WIDTH, 4, operand and sum width in bits; matches the adder.
- NREQ, 4, number of requesters; must be ≥ 2.
- IDW, 2, width of the requester index; equals clog2(NREQ).
- ADD_LAT, 1, adder latency: clock edges from operand change to valid `add_sum`; must be ≥ 1.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  flattened operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  flattened operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot grant/accept for the current cycle.
- add_a  out  WIDTH  registered operand A to the adder.
- add_b  out  WIDTH  registered operand B to the adder.
- add_sum  in  WIDTH  adder result.
- rsp_valid  out  1  response valid.
- rsp_sum  out  WIDTH  captured sum.
- rsp_id  out  IDW  index of the requester the response belongs to.
- rsp_ready  in  1  response consumer ready.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready = one-hot(winner), combinational; all zero if no req_valid.
  - On an edge where the winner's valid is high, the transfer occurs:
    - add_a/add_b ← winner's operands.
    - grant_id ← winner.
    - cnt ← ADD_LAT.
    - state → WAIT.
- **WAIT**
  - req_ready = 0.
  - If cnt ≠ 0: cnt ← cnt−1.
  - If cnt = 0: rsp_sum ← add_sum, rsp_id ← grant_id, rsp_valid ← 1, state → RESP.
- **RESP**
  - req_ready = 0.
  - rsp_valid, rsp_sum and rsp_id are held stable while rsp_ready is low.
  - On rsp_valid & rsp_ready:
    - rsp_valid ← 0.
    - rr_ptr ← (grant_id+1) mod NREQ.
    - state → IDLE.
- add_a/add_b hold their value from acceptance until the next acceptance; they are not cleared between operations.
- Arithmetic: the sum is WIDTH bits, modulo 2^WIDTH, as produced by the adder. Carry-out is not reported. The block passes `add_sum` through unmodified.
- A requester may drop req_valid before it is granted; nothing is committed. Once a transfer occurs, the operation always completes unless reset intervenes.
- Requests arriving in WAIT or RESP are not accepted; they wait for IDLE.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, rr_ptr = 0, grant_id = 0, cnt = 0.
  - add_a = add_b = 0.
  - rsp_valid = 0, rsp_sum = 0, rsp_id = 0.
  - busy = 0, req_ready = 0.
- Reset mid-operation aborts the operation. The in-flight result is discarded and no response is issued. The first post-reset grant searches from requester 0.
- Acceptance at edge E0:
  - The adder samples the operands at E0+1 … E0+ADD_LAT.
  - The sum is captured at edge E0+ADD_LAT+1.
  - rsp_valid is high from E0+ADD_LAT+1.
- Accept-to-response latency is ADD_LAT+1 cycles. With ADD_LAT=1, rsp_valid rises 2 cycles after acceptance.
- The earliest next acceptance is the edge after the response handshake, because req_ready only asserts in IDLE. A handshake at edge H puts the FSM in IDLE after H, so the next transfer can occur at H+1.
- Peak throughput with rsp_ready tied high: one operation per ADD_LAT+3 cycles.
- Response handshake coinciding with a pending req_valid: the request is not accepted that cycle. It is arbitrated in IDLE on the next cycle with the updated rr_ptr.
- rr_ptr wraps from NREQ−1 to 0.

## Test plan
- Single request: req_valid[1]=1, A=4'h3, B=4'h5.
  - req_ready[1] pulses for one cycle.
  - rsp_valid rises 2 cycles later with rsp_sum=4'h8, rsp_id=1.
  - busy is high from the cycle after acceptance until the handshake.
- Wrap-around: A=4'hF, B=4'h1 → rsp_sum=4'h0. A=4'hA, B=4'h9 → rsp_sum=4'h3.
- Fairness: all four req_valid held high, rsp_ready=1.
  - Grants follow the order 0,1,2,3,0.
  - Each rsp_id matches its grant and each sum matches its operands.
- Pointer: after a grant to requester 2, only requesters 1 and 3 are valid → requester 3 is granted, then requester 1.
- Backpressure: rsp_ready held low for 5 cycles in RESP.
  - rsp_valid, rsp_sum and rsp_id stay stable.
  - req_ready stays all zero.
  - The handshake completes when rsp_ready rises.
- Reset mid-WAIT: rst_n asserted one cycle after acceptance.
  - All outputs return to their reset values immediately.
  - No response is ever issued for that request.
  - The next request from requester 0 is accepted normally.
